// File: rtl/console_uart_tx.sv
// rtl/console_uart_tx.sv - store-snooping console FIFO feeding an 8N1 UART transmitter
module console_uart_tx #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_FFFC,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          memwrite,
    input  logic [31:0]                   dataadr,
    input  logic [31:0]                   writedata,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]     DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic [1:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_q;

    logic hit;
    logic push;
    logic pop;
    logic drop;
    logic bit_done;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:8];

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);

    assign hit      = memwrite && (dataadr == CONSOLE_ADDR);
    assign bit_done = (baud_cnt == LAST_CNT);
    // A pop on the final STOP cycle lets a full FIFO still accept a store that same cycle.
    assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
    assign push     = hit && (!fifo_full || pop);
    assign drop     = hit && fifo_full && !pop;

    assign tx      = tx_q;
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // tx_q is loaded with the level of the state being entered, so the pin changes on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                        tx_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        tx_q     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            state   <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx_q  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// tb/tb_console_uart_tx.sv - directed bench for console_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_console_uart_tx;

    localparam logic [31:0] ADDR = 32'h0000_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        tx;
    logic        tx_busy;
    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    console_uart_tx #(
        .CONSOLE_ADDR (ADDR),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives the store so the next rising edge samples it.
    task automatic store(input logic [31:0] a, input logic [7:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = {24'hA5C3E1, d};
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    // Sample k is taken at the falling edge after rising edge S+k, S being the start-bit edge.
    task automatic check_frame(input logic [7:0] d, input int first, input int last,
                               input logic inj, input logic [7:0] inj_d);
        for (int k = first; k <= last; k++) begin
            int   b;
            logic e;
            b = k / 4;
            if (b == 0)      e = 1'b0;
            else if (b == 9) e = 1'b1;
            else             e = d[b-1];
            chk($sformatf("tx_%02h_s%0d", d, k), tx, e);
            if (k == 0 || k == 39) chk($sformatf("busy_%02h_s%0d", d, k), tx_busy, 1'b1);
            if (inj && k == 39) begin
                memwrite  = 1'b1;
                dataadr   = ADDR;
                writedata = {24'h0, inj_d};
            end
            @(negedge clk);
            if (inj && k == 39) memwrite = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_drops", drop_count, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_tx", tx, 1'b1);
        chk("idle_empty", fifo_empty, 1'b1);

        store(32'h0000_0054, 8'h41);
        chk("nohit_count", fifo_count, 3'd0);
        store(32'h8000_FFFC, 8'h41);
        chk("nohit_hi_count", fifo_count, 3'd0);
        @(negedge clk);
        chk("nohit_tx", tx, 1'b1);
        chk("nohit_busy", tx_busy, 1'b0);

        store(ADDR, 8'h41);
        chk("single_count", fifo_count, 3'd1);
        chk("single_tx_pre", tx, 1'b1);
        chk("single_busy_pre", tx_busy, 1'b0);
        @(negedge clk);
        chk("single_empty_pop", fifo_empty, 1'b1);
        check_frame(8'h41, 0, 39, 1'b0, 8'h00);
        chk("single_busy_end", tx_busy, 1'b0);
        chk("single_tx_end", tx, 1'b1);
        @(negedge clk);

        store(ADDR, "H");
        store(ADDR, "i");
        chk("b2b_count", fifo_count, 3'd1);
        check_frame("H", 0, 39, 1'b0, 8'h00);
        check_frame("i", 0, 39, 1'b0, 8'h00);
        chk("b2b_busy_end", tx_busy, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 6; i++) store(ADDR, 8'(8'h30 + i));
        chk("ovf_count", fifo_count, 3'd4);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", drop_count, 8'd1);
        check_frame("0", 4, 39, 1'b1, "6");
        chk("fullpop_count", fifo_count, 3'd4);
        chk("fullpop_full", fifo_full, 1'b1);
        chk("fullpop_drops", drop_count, 8'd1);
        check_frame("1", 0, 39, 1'b0, 8'h00);
        check_frame("2", 0, 39, 1'b0, 8'h00);
        check_frame("3", 0, 39, 1'b0, 8'h00);
        check_frame("4", 0, 39, 1'b0, 8'h00);
        check_frame("6", 0, 39, 1'b0, 8'h00);
        chk("ovf_busy_end", tx_busy, 1'b0);
        chk("ovf_empty_end", fifo_empty, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);
        chk("ovf_drops_end", drop_count, 8'd1);
        @(negedge clk);

        store(ADDR, 8'h41);
        store(ADDR, 8'h42);
        check_frame(8'h41, 0, 17, 1'b0, 8'h00);
        chk("midrst_tx_before", tx, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_empty", fifo_empty, 1'b1);
        chk("midrst_count", fifo_count, 3'd0);
        chk("midrst_ovf", overflow, 1'b0);
        chk("midrst_drops", drop_count, 8'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_tx", tx, 1'b1);
        store(ADDR, 8'h43);
        chk("postrst_count", fifo_count, 3'd1);
        @(negedge clk);
        check_frame(8'h43, 0, 39, 1'b0, 8'h00);
        chk("postrst_busy_end", tx_busy, 1'b0);
        chk("postrst_empty", fifo_empty, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Memory-mapped console peripheral on the core's data-memory write port (memwrite/dataadr/writedata). It sits directly downstream of the core's store path.
- Each store to CONSOLE_ADDR pushes writedata[7:0] into a small FIFO.
- A UART transmitter drains the FIFO as 8N1 frames on the tx pin.
- This moves the console print path from a simulation-only $write to real hardware. The block also snoops the bus for status and overflow accounting.

Parameters:
- CONSOLE_ADDR, 32'h0000_FFFC (65532), store address treated as a console character write.
- FIFO_DEPTH, 16, character FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 868, clk cycles per UART bit; minimum 2.
- CNT_W, 16, width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset); async assert, release synchronous to clk.
- memwrite  in  1  core store strobe, valid for one cycle per store.
- dataadr  in  32  core store byte address.
- writedata  in  32  core store data; only bits [7:0] are used.
- tx  out  1  UART serial output; idle high.
- tx_busy  out  1  high while a frame is on the line (START/DATA/STOP).
- fifo_empty  out  1  FIFO holds no characters.
- fifo_full  out  1  FIFO holds FIFO_DEPTH characters.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued characters.
- overflow  out  1  sticky; set when a character is dropped.
- drop_count  out  8  dropped characters, saturating at 255.

Behaviour:

Reset (reset=0, asynchronous):
- tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, drop_count=0.
- Pointers, baud counter and bit index go to 0; FSM goes to IDLE.
- Reset mid-frame aborts the frame immediately: tx returns high without waiting for a clk edge.

Hit detection:
- hit = memwrite && (dataadr == CONSOLE_ADDR), full 32-bit compare.
- Stores to any other address are ignored.

FIFO:
- Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
- fifo_count is the occupancy; full/empty are derived from fifo_count.
- push = hit && (!fifo_full || pop). Push and pop in the same cycle are both honoured, and fifo_count is unchanged.
- When hit && fifo_full && !pop, the character is dropped: overflow is set to 1 and drop_count increments, saturating at 255.
- overflow and drop_count clear only on reset.

Transmit FSM (states IDLE, START, DATA, STOP):
- IDLE:
  - tx=1.
  - If !fifo_empty, pop the head into an 8-bit shift register, clear the baud counter and go to START.
  - A push into an empty FIFO at edge N is popped at edge N+1, so tx falls after edge N+1. There is no same-cycle bypass.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0], LSB first.
  - After CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After bit 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the final STOP cycle: if !fifo_empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx_busy=1 in START, DATA and STOP.
- tx is driven from a register, so the output is glitch-free.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.

Test Plan:
- Bench settings for all scenarios: CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset and idle: hold reset=0 for 3 cycles, then release -> tx=1, fifo_empty=1, fifo_count=0, overflow=0, drop_count=0; non-hit store to address 0x54 -> no change.
- Single char: store 0x41 to 65532 at edge N -> fifo_count=1 after N; tx=0 from edge N+1 for 4 cycles; data bits 1,0,0,0,0,0,1,0 at 4 cycles each; stop=1; tx_busy low 40 cycles after N+1; fifo_empty=1 after the pop.
- Back-to-back: store "H","i" on consecutive cycles -> frames contiguous; second start bit begins exactly 40 cycles after the first, with no idle high gap.
- Overflow: 6 hit stores on consecutive cycles starting from empty -> first char popped after 1 cycle; 4 queued, fifo_full=1; 6th store dropped; overflow=1, drop_count=1; decoded output "012345" minus the dropped char.
- Full with simultaneous pop: FIFO full, and a hit lands on the final STOP cycle -> char accepted, fifo_count stays 4, drop_count unchanged.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 immediately without a clk edge; FIFO empties; after release, a new store transmits cleanly.
